// File: rtl/hart_pkg.sv
// rtl/hart_pkg.sv - shared hart constants, fetch state encoding and instruction lengths
package hart_pkg;

    localparam logic [63:0] RESET_VEC_DEF = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_IR        = 32'h0000_0013;

    localparam logic [2:0] ILEN_C = 3'd2;
    localparam logic [2:0] ILEN_W = 3'd4;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_PEND = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - fetch stage bundle: icache address/data, redirects, backend stall and IF/ID register
interface fetch_if;

    logic [63:0] pc;
    logic [31:0] ir;
    logic        stall_imem;
    logic        stall;
    logic        trap;
    logic [63:0] trap_pc;
    logic        br;
    logic [63:0] br_pc;
    logic [63:0] id_pc;
    logic [31:0] id_ir;
    logic        id_valid;
    logic        id_rvc;
    logic        id_iam;

    modport master (
        output pc, id_pc, id_ir, id_valid, id_rvc, id_iam,
        input  ir, stall_imem, stall, trap, trap_pc, br, br_pc
    );

    modport slave (
        input  pc, id_pc, id_ir, id_valid, id_rvc, id_iam,
        output ir, stall_imem, stall, trap, trap_pc, br, br_pc
    );

endinterface

// File: rtl/fetch_npc.sv
// rtl/fetch_npc.sv - next-PC, compressed flag and misalignment decode; RV6_RVC_EN enables 16-bit lengths
module fetch_npc
    import hart_pkg::*;
(
    input  logic [63:0] i_pc,
    input  logic [31:0] i_ir,
    output logic [63:0] o_npc,
    output logic        o_is_rvc,
    output logic        o_misaligned
);

`ifdef RV6_RVC_EN
    assign o_is_rvc     = (i_ir[1:0] != 2'b11);
    assign o_misaligned = i_pc[0];
    assign o_npc        = i_pc + {61'd0, (o_is_rvc ? ILEN_C : ILEN_W)};
`else
    // Without compressed support a short encoding still steps by 4; decode rejects it.
    logic w_unused_ir;
    assign w_unused_ir  = ^i_ir;
    assign o_is_rvc     = 1'b0;
    assign o_misaligned = |i_pc[1:0];
    assign o_npc        = i_pc + {61'd0, ILEN_W};
`endif

endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage owning the PC and IF/ID register; RV6_RVC_EN selects compressed support
module fetch
    import hart_pkg::*;
#(
    parameter logic [63:0] RESET_VEC = RESET_VEC_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);

    fetch_state_e r_state, w_state_nxt;
    logic [63:0]  r_pc, w_pc_nxt;
    logic [63:0]  r_pend_pc, w_pend_pc_nxt;
    logic [63:0]  r_id_pc, w_id_pc_nxt;
    logic [31:0]  r_id_ir, w_id_ir_nxt;
    logic         r_id_valid, w_id_valid_nxt;
    logic         r_id_rvc, w_id_rvc_nxt;
    logic         r_id_iam, w_id_iam_nxt;

    logic         w_rd;
    logic [63:0]  w_rd_pc;
    logic [63:0]  w_npc;
    logic         w_is_rvc;
    logic         w_misaligned;

    assign w_rd    = bus.trap | bus.br;
    assign w_rd_pc = bus.trap ? bus.trap_pc : bus.br_pc;

    fetch_npc u_npc (
        .i_pc         (r_pc),
        .i_ir         (bus.ir),
        .o_npc        (w_npc),
        .o_is_rvc     (w_is_rvc),
        .o_misaligned (w_misaligned)
    );

    // The PC only moves on edges where the cache is idle, so redirects during a fill park in pend_pc.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pend_pc_nxt  = r_pend_pc;
        w_id_pc_nxt    = r_id_pc;
        w_id_ir_nxt    = r_id_ir;
        w_id_valid_nxt = r_id_valid;
        w_id_rvc_nxt   = r_id_rvc;
        w_id_iam_nxt   = r_id_iam;
        case (r_state)
            FETCH_RUN: begin
                if (w_rd && !bus.stall_imem) begin
                    w_pc_nxt       = w_rd_pc;
                    w_id_valid_nxt = 1'b0;
                end else if (w_rd) begin
                    w_pend_pc_nxt  = w_rd_pc;
                    w_id_valid_nxt = 1'b0;
                    w_state_nxt    = FETCH_PEND;
                end else if (bus.stall) begin
                    w_pc_nxt = r_pc;
                end else if (bus.stall_imem) begin
                    w_id_valid_nxt = 1'b0;
                end else begin
                    w_id_pc_nxt    = r_pc;
                    w_id_ir_nxt    = bus.ir;
                    w_id_rvc_nxt   = w_is_rvc;
                    w_id_iam_nxt   = w_misaligned;
                    w_id_valid_nxt = 1'b1;
                    w_pc_nxt       = w_npc;
                end
            end
            FETCH_PEND: begin
                w_id_valid_nxt = 1'b0;
                if (w_rd) begin
                    w_pend_pc_nxt = w_rd_pc;
                end
                if (!bus.stall_imem) begin
                    w_pc_nxt    = w_rd ? w_rd_pc : r_pend_pc;
                    w_state_nxt = FETCH_RUN;
                end
            end
            default: begin
                w_state_nxt = FETCH_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= FETCH_RUN;
            r_pc       <= RESET_VEC;
            r_pend_pc  <= 64'd0;
            r_id_pc    <= 64'd0;
            r_id_ir    <= NOP_IR;
            r_id_valid <= 1'b0;
            r_id_rvc   <= 1'b0;
            r_id_iam   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pend_pc  <= w_pend_pc_nxt;
            r_id_pc    <= w_id_pc_nxt;
            r_id_ir    <= w_id_ir_nxt;
            r_id_valid <= w_id_valid_nxt;
            r_id_rvc   <= w_id_rvc_nxt;
            r_id_iam   <= w_id_iam_nxt;
        end
    end

    assign bus.pc       = r_pc;
    assign bus.id_pc    = r_id_pc;
    assign bus.id_ir    = r_id_ir;
    assign bus.id_valid = r_id_valid;
    assign bus.id_rvc   = r_id_rvc;
    assign bus.id_iam   = r_id_iam;

endmodule
